// File: rtl/uart2wb_burst_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge: command
// characters, reply characters, FSM state encoding and ASCII hex helpers.
package uart2wb_burst_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_CNT,
    S_WR,
    S_RD,
    S_TX
  } state_t;

  // Command characters
  localparam logic [7:0] CH_ABORT   = 8'h2E;  // '.'
  localparam logic [7:0] CH_ADDR    = 8'h70;  // 'p'
  localparam logic [7:0] CH_WRITE   = 8'h77;  // 'w'
  localparam logic [7:0] CH_READ    = 8'h72;  // 'r'
  localparam logic [7:0] CH_BURST   = 8'h62;  // 'b'

  // Reply characters
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;  // '?'
  localparam logic [7:0] CH_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] CH_TIMEOUT = 8'h21;  // '!'
  localparam logic [7:0] CH_NL      = 8'h0A;  // '\n'

  // Lowercase 'b' collides with the burst command; the command wins so that
  // "p..b03" and a bare "b" behave as bursts. 'B' is still a hex digit.
  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66 && c != CH_BURST);
  endfunction

  function automatic logic [3:0] hex2nib(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    else            return c[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart2wb_burst_uart_hex_tx.sv
// Character serializer with the UART tx handshake. Sends either one raw
// character or a data word as uppercase hex, MSB nibble first. A send is
// never issued while the transmitter is busy or in the cycle after a send.
module uart_hex_tx
  import uart2wb_burst_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_raw,
  input  logic [DATA_W-1:0] word,
  input  logic [7:0]        raw_char,
  input  logic              tx_busy,
  output logic [7:0]        tx_dat,
  output logic              tx_send,
  output logic              active,
  output logic              done
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2(NIB + 1);

  logic              raw_q;
  logic              sent_last;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sh;
  logic [7:0]        ch;
  logic              last;

  // Handshake and output character selection
  always_comb begin
    tx_send = active && !tx_busy && !sent_last;
    last    = raw_q || (cnt == CNT_W'(1));
    done    = tx_send && last;
    tx_dat  = 8'h00;
    if (active) tx_dat = raw_q ? ch : nib2hex(sh[DATA_W-1 -: 4]);
  end

  // Control state: activity, mode, remaining characters, send spacing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active    <= 1'b0;
      raw_q     <= 1'b0;
      sent_last <= 1'b0;
      cnt       <= '0;
    end else begin
      sent_last <= tx_send;
      if (load) begin
        active <= 1'b1;
        raw_q  <= load_raw;
        cnt    <= CNT_W'(NIB);
      end else if (tx_send) begin
        if (last) active <= 1'b0;
        else      cnt    <= cnt - CNT_W'(1);
      end
    end
  end

  // Data holding: word shifts one nibble per hex character sent
  always_ff @(posedge clk) begin
    if (load) begin
      sh <= word;
      ch <= raw_char;
    end else if (tx_send) begin
      sh <= sh << 4;
    end
  end

endmodule

// File: rtl/uart2wb_burst.sv
// UART-to-Wishbone debug bridge. Parses ASCII hex commands (p=address,
// w=write, r=read, b=burst read, .=abort), runs the bus access with an ack
// timeout, and returns read data or status characters over the UART tx.
module uart2wb_burst
  import uart2wb_burst_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 8
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst_n,
  input  logic              i_wb_ack,
  input  logic [DATA_W-1:0] i_wb_dat,
  output logic [DATA_W-1:0] o_wb_dat,
  output logic              o_wb_stb,
  output logic              o_wb_cyc,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic              o_wb_rw,
  input  logic [7:0]        i_rx_dat,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_dat,
  output logic              o_tx_send,
  input  logic              i_tx_busy
);

  localparam int NIB   = DATA_W / 4;
  localparam int NIB_W = $clog2(NIB + 1);

  state_t                 state, state_n;
  logic [ADDR_W-1:0]      addr, addr_n;
  logic [DATA_W-1:0]      wb_dat, dat_n;
  logic                   stb, stb_n;
  logic                   rw, rw_n;
  logic [TIMEOUT_W-1:0]   to_cnt, to_n, to_nx;
  logic [7:0]             count, count_n;
  logic [NIB_W-1:0]       nib_cnt, nib_n;
  logic                   rx_hex;
  logic [3:0]             rx_nib;
  logic                   ld, ld_raw;
  logic [7:0]             ld_char;
  logic                   tx_active, tx_done;

  assign o_wb_dat  = wb_dat;
  assign o_wb_stb  = stb;
  assign o_wb_cyc  = stb;
  assign o_wb_addr = addr;
  assign o_wb_rw   = rw;

  // Reply path: hex read data and single status characters share one serializer
  uart_hex_tx #(.DATA_W(DATA_W)) u_hex_tx (
    .clk      (i_wb_clk),
    .rst_n    (i_wb_rst_n),
    .load     (ld),
    .load_raw (ld_raw),
    .word     (i_wb_dat),
    .raw_char (ld_char),
    .tx_busy  (i_tx_busy),
    .tx_dat   (o_tx_dat),
    .tx_send  (o_tx_send),
    .active   (tx_active),
    .done     (tx_done)
  );

  // Next-state logic: command parsing, bus access control, reply queueing
  always_comb begin
    state_n = state;
    addr_n  = addr;
    dat_n   = wb_dat;
    stb_n   = stb;
    rw_n    = rw;
    to_n    = to_cnt;
    count_n = count;
    nib_n   = nib_cnt;
    ld      = 1'b0;
    ld_raw  = 1'b1;
    ld_char = CH_OK;
    rx_hex  = is_hex(i_rx_dat);
    rx_nib  = hex2nib(i_rx_dat);
    to_nx   = to_cnt + TIMEOUT_W'(1);

    case (state)
      S_IDLE, S_ADDR, S_WDATA, S_CNT: begin
        // A pending reply character blocks parsing; that rx byte is lost.
        if (i_rx_valid && !tx_active) begin
          if (rx_hex) begin
            if (state == S_ADDR) begin
              addr_n = {addr[ADDR_W-5:0], rx_nib};
            end else if (state == S_WDATA) begin
              dat_n = {wb_dat[DATA_W-5:0], rx_nib};
              if (nib_cnt == NIB_W'(NIB - 1)) begin
                state_n = S_WR;
                stb_n   = 1'b1;
                rw_n    = 1'b0;
                to_n    = '0;
              end else begin
                nib_n = nib_cnt + NIB_W'(1);
              end
            end else if (state == S_CNT) begin
              count_n = {count[3:0], rx_nib};
              if (nib_cnt == NIB_W'(1)) begin
                state_n = S_RD;
                stb_n   = 1'b1;
                rw_n    = 1'b1;
                to_n    = '0;
              end else begin
                nib_n = nib_cnt + NIB_W'(1);
              end
            end
          end else begin
            // Non-hex ends any field and is handled as a fresh command.
            nib_n   = '0;
            state_n = S_IDLE;
            case (i_rx_dat)
              CH_ABORT: begin
                state_n = S_IDLE;
              end
              CH_ADDR: begin
                state_n = S_ADDR;
                addr_n  = '0;
              end
              CH_WRITE: begin
                state_n = S_WDATA;
              end
              CH_READ: begin
                state_n = S_RD;
                count_n = '0;
                stb_n   = 1'b1;
                rw_n    = 1'b1;
                to_n    = '0;
              end
              CH_BURST: begin
                state_n = S_CNT;
                count_n = '0;
              end
              default: begin
                ld      = 1'b1;
                ld_char = CH_UNKNOWN;
              end
            endcase
          end
        end
      end

      S_WR, S_RD: begin
        // Ack beats a simultaneous timeout.
        if (i_wb_ack) begin
          stb_n = 1'b0;
          ld    = 1'b1;
          if (state == S_WR) begin
            addr_n  = addr + ADDR_W'(1);
            ld_char = CH_OK;
            state_n = S_IDLE;
          end else begin
            ld_raw  = 1'b0;
            state_n = S_TX;
          end
        end else if (to_nx == '1) begin
          stb_n   = 1'b0;
          ld      = 1'b1;
          ld_char = CH_TIMEOUT;
          state_n = S_IDLE;
        end else begin
          to_n = to_nx;
        end
      end

      S_TX: begin
        if (tx_done) begin
          addr_n = addr + ADDR_W'(1);
          if (count == 8'd0) begin
            ld      = 1'b1;
            ld_char = CH_NL;
            state_n = S_IDLE;
          end else begin
            count_n = count - 8'd1;
            stb_n   = 1'b1;
            rw_n    = 1'b1;
            to_n    = '0;
            state_n = S_RD;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      state   <= S_IDLE;
      addr    <= '0;
      wb_dat  <= '0;
      stb     <= 1'b0;
      rw      <= 1'b0;
      to_cnt  <= '0;
      count   <= '0;
      nib_cnt <= '0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      wb_dat  <= dat_n;
      stb     <= stb_n;
      rw      <= rw_n;
      to_cnt  <= to_n;
      count   <= count_n;
      nib_cnt <= nib_n;
    end
  end

endmodule

// File: tb/tb_uart2wb_burst.sv
// Directed bench for uart2wb_burst: ASCII command strings in, Wishbone
// accesses and UART reply characters checked against hand-computed values.
module tb_uart2wb_burst;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ack = 1'b0;
  logic [DATA_W-1:0] wb_rdat = '0;
  logic [DATA_W-1:0] wb_wdat;
  logic              wb_stb, wb_cyc, wb_rw;
  logic [ADDR_W-1:0] wb_addr;
  logic [7:0]        rx_dat = 8'h00;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_dat;
  logic              tx_send;
  logic              tx_busy = 1'b0;

  always #5 clk = ~clk;

  uart2wb_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_wb_ack   (ack),
    .i_wb_dat   (wb_rdat),
    .o_wb_dat   (wb_wdat),
    .o_wb_stb   (wb_stb),
    .o_wb_cyc   (wb_cyc),
    .o_wb_addr  (wb_addr),
    .o_wb_rw    (wb_rw),
    .i_rx_dat   (rx_dat),
    .i_rx_valid (rx_valid),
    .o_tx_dat   (tx_dat),
    .o_tx_send  (tx_send),
    .i_tx_busy  (tx_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Slave configuration and bus log
  bit                ack_en = 1'b1;
  bit                rd_mode = 1'b0;
  logic [7:0]        rd_val = 8'h00;
  logic [ADDR_W-1:0] log_addr[$];
  logic              log_rw[$];
  logic [DATA_W-1:0] log_dat[$];

  // UART tx side
  logic [7:0] tx_q[$];
  int         send_count = 0;
  int         hs_err = 0;
  logic       prev_send = 1'b0;
  int         busy_len = 0;
  int         tx_rd = 0;

  // Wishbone slave: single-cycle ack one half-cycle after stb is seen
  always @(negedge clk) begin
    logic [DATA_W-1:0] d;
    if (wb_stb && ack_en && !ack) begin
      d = rd_mode ? wb_addr[7:0] : rd_val;
      log_addr.push_back(wb_addr);
      log_rw.push_back(wb_rw);
      log_dat.push_back(wb_rw ? d : wb_wdat);
      wb_rdat = d;
      ack = 1'b1;
    end else begin
      ack = 1'b0;
    end
  end

  // UART tx capture and handshake watch
  always @(negedge clk) begin
    if (tx_send) begin
      if (tx_busy || prev_send) hs_err++;
      tx_q.push_back(tx_dat);
      send_count++;
    end
    prev_send = tx_send;
  end

  // Transmitter model: busy for busy_len cycles after each accepted character
  always begin
    int seen;
    int left;
    seen = 0;
    left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (send_count != seen) begin
        seen = send_count;
        left = busy_len;
      end
      if (left > 0) begin
        tx_busy = 1'b1;
        left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic rx_pulse(input logic [7:0] c);
    @(negedge clk);
    rx_dat   = c;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_pulse(s[i]);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic expect_tx(input string tag, input string s);
    int base;
    int cyc;
    logic [7:0] got;
    logic [7:0] want;
    base = tx_rd;
    cyc  = 0;
    while (tx_q.size() < base + s.len() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    check({tag, "_count"}, 32'(tx_q.size()), 32'(base + s.len()));
    for (int i = 0; i < s.len(); i++) begin
      got  = (base + i < tx_q.size()) ? tx_q[base + i] : 8'h00;
      want = s[i];
      check($sformatf("%s_ch%0d", tag, i), 32'(got), 32'(want));
    end
    check({tag, "_handshake"}, 32'(hs_err), 32'd0);
    tx_rd = tx_q.size();
  endtask

  task automatic check_bus(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                           input logic rw, input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] ga;
    logic              grw;
    logic [DATA_W-1:0] gd;
    ga  = (idx < log_addr.size()) ? log_addr[idx] : '1;
    grw = (idx < log_rw.size())   ? log_rw[idx]   : 1'bx;
    gd  = (idx < log_dat.size())  ? log_dat[idx]  : 'x;
    check({tag, "_addr"}, 32'(ga), 32'(a));
    check({tag, "_rw"},   32'(grw), 32'(rw));
    check({tag, "_dat"},  32'(gd), 32'(d));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stb",    32'(wb_stb),  32'd0);
    check("rst_cyc",    32'(wb_cyc),  32'd0);
    check("rst_send",   32'(tx_send), 32'd0);
    check("rst_addr",   32'(wb_addr), 32'd0);
    check("rst_wdat",   32'(wb_wdat), 32'd0);
    check("rst_rw",     32'(wb_rw),   32'd0);
    check("rst_txdat",  32'(tx_dat),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write with stb latency
    send_str("p123456w5");
    check("t1_pre_stb", 32'(wb_stb), 32'd0);
    rx_pulse("A");
    check("t1_stb",  32'(wb_stb),  32'd1);
    check("t1_cyc",  32'(wb_cyc),  32'd1);
    check("t1_rw",   32'(wb_rw),   32'd0);
    check("t1_dat",  32'(wb_wdat), 32'h5A);
    check("t1_addr", 32'(wb_addr), 32'h123456);
    expect_tx("t1_tx", "K");
    check("t1_addr_inc", 32'(wb_addr), 32'h123457);
    check_bus("t1_bus", 0, 24'h123456, 1'b0, 8'h5A);

    // Single read with a slow transmitter
    busy_len = 5;
    rd_val   = 8'hC3;
    send_str("p10r");
    expect_tx("t2_tx", "C3\n");
    check("t2_addr", 32'(wb_addr), 32'h000011);
    check_bus("t2_bus", 1, 24'h000010, 1'b1, 8'hC3);
    busy_len = 0;

    // Burst of four reads with data wrap, back-to-back sends
    rd_mode = 1'b1;
    send_str("p00FFFEb03");
    expect_tx("t3_tx", "FEFF0001\n");
    check("t3_addr", 32'(wb_addr), 32'h010002);
    check_bus("t3_bus0", 2, 24'h00FFFE, 1'b1, 8'hFE);
    check_bus("t3_bus1", 3, 24'h00FFFF, 1'b1, 8'hFF);
    check_bus("t3_bus2", 4, 24'h010000, 1'b1, 8'h00);
    check_bus("t3_bus3", 5, 24'h010001, 1'b1, 8'h01);
    check("t3_nbus", 32'(log_addr.size()), 32'd6);
    rd_mode = 1'b0;

    // Address wrap at the top of the space
    send_str("pFFFFFFw00");
    expect_tx("t3b_tx", "K");
    check("t3b_addr", 32'(wb_addr), 32'h000000);
    check_bus("t3b_bus", 6, 24'hFFFFFF, 1'b0, 8'h00);

    // Extra address digits shift out the MSBs
    send_str("p1234567.");
    check("t3c_addr", 32'(wb_addr), 32'h234567);

    // Lowercase address, then read timeout
    send_str("pfe.");
    check("t4_addr_lc", 32'(wb_addr), 32'h0000FE);
    ack_en = 1'b0;
    rx_pulse("r");
    n = 0;
    while (wb_stb && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t4_stb_cycles", 32'(n), 32'd15);
    expect_tx("t4_tx", "!");
    check("t4_addr", 32'(wb_addr), 32'h0000FE);
    check("t4_nbus", 32'(log_addr.size()), 32'd7);
    ack_en = 1'b1;

    // Unknown character, aborted write, lowercase write data
    send_str("w5Z");
    expect_tx("t5_tx_unk", "?");
    check("t5_nbus_unk", 32'(log_addr.size()), 32'd7);
    rd_val = 8'h3A;
    send_str("w5.r");
    expect_tx("t5_tx_rd", "3A\n");
    check("t5_nbus_rd", 32'(log_addr.size()), 32'd8);
    check_bus("t5_bus_rd", 7, 24'h0000FE, 1'b1, 8'h3A);
    check("t5_addr_rd", 32'(wb_addr), 32'h0000FF);
    send_str("wc3");
    expect_tx("t5_tx_wr", "K");
    check_bus("t5_bus_wr", 8, 24'h0000FF, 1'b0, 8'hC3);
    check("t5_addr_wr", 32'(wb_addr), 32'h000100);

    // Reset in the middle of a burst read
    ack_en = 1'b0;
    send_str("p20b05");
    check("t6_stb_before", 32'(wb_stb),  32'd1);
    check("t6_addr_before", 32'(wb_addr), 32'h000020);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_stb",  32'(wb_stb),  32'd0);
    check("t6_cyc",  32'(wb_cyc),  32'd0);
    check("t6_send", 32'(tx_send), 32'd0);
    check("t6_addr", 32'(wb_addr), 32'd0);
    check("t6_rw",   32'(wb_rw),   32'd0);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    rd_val = 8'h5E;
    @(negedge clk);
    send_str("r");
    expect_tx("t6_tx", "5E\n");
    check_bus("t6_bus", 9, 24'h000000, 1'b1, 8'h5E);
    check("t6_addr_after", 32'(wb_addr), 32'h000001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
